// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants for the RAM arbiter/sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int         c_STATE_W  = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    localparam int c_RAM_LAT_MIN = 1;
    localparam int c_RAM_LAT_MAX = 4;
    localparam int c_CNT_W       = 2;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin grant; last_grant is held by parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic i_elig_cpu,
    input  logic i_elig_dbg,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_owner
);

    always_comb begin
        o_valid = i_elig_cpu | i_elig_dbg;
        o_owner = OWN_CPU;
        if (i_elig_cpu && i_elig_dbg) begin
            o_owner = ~i_last_grant;
        end else if (i_elig_dbg) begin
            o_owner = OWN_DBG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one synchronous RAM between the CPU and a debug port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    input  logic              dbg_hold,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              owner
);

    // Out-of-range latencies are clamped to the supported window.
    localparam int c_LAT = (RAM_LAT < c_RAM_LAT_MIN) ? c_RAM_LAT_MIN :
                           (RAM_LAT > c_RAM_LAT_MAX) ? c_RAM_LAT_MAX : RAM_LAT;
    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(c_LAT - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_owner;
    logic                 r_last_grant;
    logic [DATA_W-1:0]    r_cpu_rdata;
    logic [DATA_W-1:0]    r_dbg_rdata;

    logic w_grant_valid;
    logic w_grant_owner;
    logic w_last_wait;
    logic w_unused_addr_bits;

    assign w_unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                  dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    rr_arb2 u_rr_arb2 (
        .i_elig_cpu   (cpu_req & ~dbg_hold),
        .i_elig_dbg   (dbg_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_grant_valid),
        .o_owner      (w_grant_owner)
    );

    assign w_last_wait = (r_state == c_ST_WAIT) && (r_cnt == c_LAT_M1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_grant_valid) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (w_last_wait) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_DBG;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner      <= w_grant_owner;
                        r_last_grant <= w_grant_owner;
                        if (w_grant_owner == OWN_DBG) begin
                            r_we    <= dbg_we;
                            r_addr  <= dbg_addr[ADDR_W+1:2];
                            r_wdata <= dbg_wdata;
                        end else begin
                            r_we    <= cpu_we;
                            r_addr  <= cpu_addr[ADDR_W+1:2];
                            r_wdata <= cpu_wdata;
                        end
                    end
                end
                c_ST_ISSUE: r_cnt <= '0;
                c_ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Read data lands only in the owning port's register.
                    if (w_last_wait && !r_we) begin
                        if (r_owner == OWN_DBG) r_dbg_rdata <= ram_dout;
                        else                    r_cpu_rdata <= ram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr  = r_addr;
    assign ram_din   = r_wdata;
    assign ram_we    = (r_state == c_ST_ISSUE) && r_we;
    assign busy      = (r_state != c_ST_IDLE);
    assign owner     = r_owner;
    assign cpu_ready = (r_state == c_ST_DONE) && (r_owner == OWN_CPU);
    assign dbg_ready = (r_state == c_ST_DONE) && (r_owner == OWN_DBG);
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (latency 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, dbg_hold = 0;
    logic [31:0]       cpu_addr = 0, dbg_addr = 0;
    logic [DATA_W-1:0] cpu_wdata = 0, dbg_wdata = 0;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata, ram_din, ram_dout;
    logic              cpu_ready, dbg_ready, ram_we, busy, owner;
    logic [ADDR_W-1:0] ram_addr;

    logic              c3_req = 0;
    logic [31:0]       c3_addr = 0;
    logic [DATA_W-1:0] c3_rdata, d3_rdata, ram3_din, ram3_dout;
    logic              c3_ready, d3_ready, ram3_we, busy3, owner3;
    logic [ADDR_W-1:0] ram3_addr;

    logic              pre_we = 0;
    logic [ADDR_W-1:0] pre_addr = 0;
    logic [DATA_W-1:0] pre_data = 0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready), .dbg_hold(dbg_hold),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .owner(owner)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(c3_req), .cpu_we(1'b0), .cpu_addr(c3_addr), .cpu_wdata(32'h0),
        .cpu_rdata(c3_rdata), .cpu_ready(c3_ready),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
        .dbg_rdata(d3_rdata), .dbg_ready(d3_ready), .dbg_hold(1'b0),
        .ram_addr(ram3_addr), .ram_we(ram3_we), .ram_din(ram3_din), .ram_dout(ram3_dout),
        .busy(busy3), .owner(owner3)
    );

    // RAM models: latency 1 and latency 3, both preloadable from the bench.
    logic [DATA_W-1:0] mem1 [1024];
    logic [DATA_W-1:0] mem3 [1024];
    logic [DATA_W-1:0] p3 [3];

    always @(posedge clk) begin
        if (pre_we)      mem1[pre_addr] <= pre_data;
        else if (ram_we) mem1[ram_addr] <= ram_din;
        ram_dout <= mem1[ram_addr];
    end

    always @(posedge clk) begin
        if (pre_we)       mem3[pre_addr]  <= pre_data;
        else if (ram3_we) mem3[ram3_addr] <= ram3_din;
        p3[0] <= mem3[ram3_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ram3_dout = p3[2];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, cpu_ready, dbg_ready, ram_we, owner} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/cpu_rdy/dbg_rdy/we/owner got %b required 00000",
                     {busy, cpu_ready, dbg_ready, ram_we, owner});
        end
        n_checks++;
        if (ram_addr !== '0 || ram_din !== '0) begin
            n_fail++;
            $display("FAIL reset_ram: addr %h din %h required 0", ram_addr, ram_din);
        end
        n_checks++;
        if (cpu_rdata !== '0 || dbg_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: cpu %h dbg %h required 0", cpu_rdata, dbg_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_cpu_read;
        @(negedge clk);
        cpu_addr = 32'h14; cpu_we = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ram_addr !== 10'd5 || ram_we !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cpu_read_issue: addr %0d we %b busy %b required 5 0 1", ram_addr, ram_we, busy);
        end
        @(negedge clk);
        n_checks++;
        if (cpu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_read_early: cpu_ready %b required 0 at N+2", cpu_ready);
        end
        @(negedge clk);
        n_checks++;
        if (cpu_ready !== 1'b1 || dbg_ready !== 1'b0 || cpu_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL cpu_read_done: rdy %b dbg_rdy %b data %h required 1 0 12345678",
                     cpu_ready, dbg_ready, cpu_rdata);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || cpu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_read_idle: busy %b rdy %b required 0 0", busy, cpu_ready);
        end
    endtask

    task automatic test_dbg_write;
        @(negedge clk);
        dbg_addr = 32'h23; dbg_wdata = 32'hDEAD_BEEF; dbg_we = 1'b1; dbg_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ram_we !== 1'b1 || ram_addr !== 10'd8 || ram_din !== 32'hDEAD_BEEF || owner !== 1'b1) begin
            n_fail++;
            $display("FAIL dbg_write_issue: we %b addr %0d din %h owner %b required 1 8 deadbeef 1",
                     ram_we, ram_addr, ram_din, owner);
        end
        @(negedge clk);
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL dbg_write_we_pulse: ram_we %b required 0 in WAIT", ram_we);
        end
        @(negedge clk);
        n_checks++;
        if (dbg_ready !== 1'b1 || cpu_ready !== 1'b0 || dbg_rdata !== 32'h0 || cpu_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL dbg_write_done: dbg_rdy %b cpu_rdy %b dbg_rd %h cpu_rd %h required 1 0 0 12345678",
                     dbg_ready, cpu_ready, dbg_rdata, cpu_rdata);
        end
        dbg_req = 1'b0; dbg_we = 1'b0;
        @(negedge clk);
        cpu_addr = 32'h20; cpu_we = 1'b0; cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL dbg_write_readback: rdy %b data %h required 1 deadbeef", cpu_ready, cpu_rdata);
        end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        dbg_addr = 32'h14; dbg_we = 1'b0; dbg_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; dbg_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, cpu_ready, dbg_ready, ram_we, owner} !== 5'b0 || ram_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: busy/rdy/rdy/we/owner %b addr %0d required 00000 0",
                     {busy, cpu_ready, dbg_ready, ram_we, owner}, ram_addr);
        end
        n_checks++;
        if (cpu_rdata !== '0 || dbg_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_rdata: cpu %h dbg %h required 0", cpu_rdata, dbg_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dbg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: busy %b dbg_rdy %b required 0 0", busy, dbg_ready);
        end
    endtask

    task automatic test_round_robin;
        logic exp_dbg;
        @(negedge clk);
        cpu_addr = 32'h28; cpu_we = 1'b0; cpu_req = 1'b1;
        dbg_addr = 32'h2C; dbg_we = 1'b0; dbg_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 3 : 4) @(negedge clk);
            exp_dbg = (k % 2) == 1;
            n_checks++;
            if (cpu_ready !== ~exp_dbg || dbg_ready !== exp_dbg || owner !== exp_dbg) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: cpu_rdy %b dbg_rdy %b owner %b required owner %b",
                         k, cpu_ready, dbg_ready, owner, exp_dbg);
            end
            n_checks++;
            if ((exp_dbg && dbg_rdata !== 32'hBBBB_0011) || (!exp_dbg && cpu_rdata !== 32'hAAAA_0010)) begin
                n_fail++;
                $display("FAIL rr_data_%0d: cpu %h dbg %h required aaaa0010/bbbb0011",
                         k, cpu_rdata, dbg_rdata);
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dbg_hold;
        @(negedge clk);
        dbg_hold = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            repeat ((k == 0) ? 3 : 4) @(negedge clk);
            n_checks++;
            if (dbg_ready !== 1'b1 || cpu_ready !== 1'b0 || owner !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_dbg_%0d: dbg_rdy %b cpu_rdy %b owner %b required 1 0 1",
                         k, dbg_ready, cpu_ready, owner);
            end
        end
        dbg_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || cpu_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cpu_blocked_%0d: busy %b cpu_rdy %b required 0 0", k, busy, cpu_ready);
            end
        end
        dbg_hold = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release_grant: busy %b owner %b required 1 0", busy, owner);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hAAAA_0010) begin
            n_fail++;
            $display("FAIL hold_release_done: rdy %b data %h required 1 aaaa0010", cpu_ready, cpu_rdata);
        end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency_wrap;
        @(negedge clk);
        c3_addr = 32'h1000; c3_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ram3_addr !== 10'd0 || busy3 !== 1'b1) begin
            n_fail++;
            $display("FAIL lat3_wrap_addr: addr %0d busy %b required 0 1", ram3_addr, busy3);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (c3_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lat3_early: ready %b required 0 at N+4", c3_ready);
        end
        @(negedge clk);
        n_checks++;
        if (c3_ready !== 1'b1 || c3_rdata !== 32'hCAFE_F00D || d3_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lat3_done: ready %b data %h dbg_rdy %b required 1 cafef00d 0",
                     c3_ready, c3_rdata, d3_ready);
        end
        c3_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (c3_ready !== 1'b0 || busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat3_pulse: ready %b busy %b required 0 0", c3_ready, busy3);
        end
    endtask

    initial begin
        test_reset;
        preload(10'd5,  32'h1234_5678);
        preload(10'd0,  32'hCAFE_F00D);
        preload(10'd10, 32'hAAAA_0010);
        preload(10'd11, 32'hBBBB_0011);
        test_cpu_read;
        test_dbg_write;
        test_reset_mid;
        test_round_robin;
        test_dbg_hold;
        test_latency_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the multi-cycle CPU's single-port synchronous instruction/data RAM. It shares the RAM between the CPU memory interface (instruction fetch and load/store) and a debug/loader port used to inspect or preload memory from switches. It serialises accesses, converts byte addresses to word addresses, and returns a one-cycle `ready` pulse per transaction; the CPU port's `cpu_ready` feeds the control unit's `MIO_ready` input.

## Interface
- `ADDR_W`, 10: RAM word-address width.
- `DATA_W`, 32: data width.
- `RAM_LAT`, 1: RAM read latency in cycles, legal range 1..4.
- `clk`  in  1  system clock, the same clock as the CPU datapath.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held with address, data and `we` stable until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_rdata`  out  DATA_W  read data; valid while `cpu_ready` = 1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `dbg_req`, `dbg_we`, `dbg_addr[31:0]`, `dbg_wdata`, `dbg_rdata`, `dbg_ready`: same semantics as the CPU port.
- `dbg_hold`  in  1  when 1, new CPU requests are not granted; a CPU transaction already in flight completes.
- `ram_addr`  out  ADDR_W  word address to the RAM.
- `ram_we`  out  1  RAM write enable.
- `ram_din`  out  DATA_W  RAM write data.
- `ram_dout`  in  DATA_W  RAM read data, valid `RAM_LAT` cycles after the address.
- `busy`  out  1  1 in any state other than IDLE.
- `owner`  out  1  port owning the current or last transaction: 0 = CPU, 1 = debug.

## Operation
- **States:** IDLE → ISSUE → WAIT → DONE → IDLE.
- **IDLE:**
  - Sample the requests and pick the winner.
  - Latch the winner's `we`, the word address `addr[ADDR_W+1:2]` and `wdata`.
  - Go to ISSUE.
  - Stay in IDLE if there is no eligible request.
- **Address rules:**
  - Address bits [1:0] are ignored; misaligned accesses act on the containing word.
  - Address bits above `ADDR_W+1` are ignored, so addresses wrap modulo the RAM size.
- **Arbitration (round-robin):**
  - The CPU is eligible when `cpu_req & ~dbg_hold`; the debug port is eligible when `dbg_req`.
  - If both are eligible, grant the port not granted last.
  - `last_grant` updates on every grant.
- **ISSUE:**
  - Drive `ram_addr` and `ram_din` from the latched values.
  - `ram_we` = latched `we`; it is high only in this state.
  - Go to WAIT.
- **WAIT:**
  - Stay `RAM_LAT` cycles, tracked by a counter.
  - On the final WAIT cycle, on a read, capture `ram_dout` into the owner's rdata register.
  - The other port's rdata register is unchanged.
  - A write leaves both rdata registers unchanged.
  - Go to DONE.
- **DONE:**
  - Assert the owner's `ready` for exactly one cycle.
  - Requests are not sampled in DONE.
  - Go to IDLE.
- **Requester rules:**
  - A requester must drop `req` in the cycle after `ready`.
  - A `req` still high in IDLE starts a new transaction.
- **Output sourcing:**
  - `ram_*`, `ready`, `busy` and `owner` decode from registered state only.
  - There is no combinational path from `*_req` to any output.
- **Reset values:**
  - State IDLE.
  - `cpu_ready`, `dbg_ready`, `ram_we` and `busy` = 0.
  - `ram_addr` = 0, `ram_din` = 0.
  - `cpu_rdata` = `dbg_rdata` = 0.
  - `owner` = 0, `last_grant` = debug, so the CPU wins the first tie.
- **Reset mid-transaction:**
  - Return to IDLE next cycle with no `ready` pulse.
  - A write whose ISSUE cycle coincides with the `rst` edge is already committed by the RAM; the RAM contents are not reset.

## Timing
- Request sampled in cycle N (IDLE).
- ISSUE in N+1, with `ram_we` pulse for writes.
- WAIT in N+2 .. N+1+`RAM_LAT`.
- `ready` in N+2+`RAM_LAT`: N+3 with the default latency.
- Back-to-back throughput: one transaction per `RAM_LAT`+3 cycles, including the IDLE sample cycle.
- A losing requester keeps waiting and is granted at the next IDLE, so worst-case wait is one full transaction.
- `dbg_hold` takes effect on the next IDLE sample.

## Structure
- Package `mem_arb_pkg`:
  - state encoding (IDLE, ISSUE, WAIT, DONE);
  - owner constants `OWN_CPU` = 0, `OWN_DBG` = 1;
  - the `RAM_LAT` legal-range constants.
- Sub-module `rr_arb2`:
  - combinational two-requester round-robin grant from the eligibility bits and `last_grant`;
  - `last_grant` register held in the parent.
- Parent module: FSM, latency counter, latch registers and rdata registers.

## Test plan
- **Reset state:** assert `rst` for 2 cycles mid-WAIT → all outputs at reset values, no `ready`, `busy` = 0 the next cycle.
- **CPU read:** RAM word 5 = 0x1234_5678; `cpu_req`, `cpu_addr` = 0x14, `we` = 0 at N → `ram_addr` = 5 at N+1, `cpu_ready` = 1 and `cpu_rdata` = 0x1234_5678 at N+3.
- **Debug write then CPU readback:**
  - `dbg_we` = 1, `dbg_addr` = 0x23 (misaligned), data 0xDEAD_BEEF → `ram_we` pulse with `ram_addr` = 8.
  - A CPU read of 0x20 then returns 0xDEAD_BEEF.
- **Simultaneous requests for 4 back-to-back transactions:** grant order CPU, DBG, CPU, DBG; each `ready` goes only to its owner.
- **`dbg_hold` = 1 with both requesting:** only debug transactions complete; `cpu_ready` stays 0 until `dbg_hold` drops, then the CPU is granted at the next IDLE.
- **Latency and wrap:** `RAM_LAT` = 3 → `ready` at N+5; `cpu_addr` = 0x1000 (`ADDR_W` = 10) accesses word 0.
